// File: rtl/change_dispenser.sv
// change_dispenser: splits a change amount into coins, largest first, and drives one hopper
// request at a time while keeping a per-denomination inventory.
module change_dispenser #(
   parameter int INV_W       = 8,
   parameter int INIT_COUNT  = 20,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [15:0]      amount,
   input  logic             load,
   input  logic [2:0]       load_type,
   input  logic [INV_W-1:0] load_count,
   input  logic             coin_ack,
   output logic             coin_req,
   output logic [2:0]       coin_type,
   output logic             busy,
   output logic             done,
   output logic [15:0]      shortfall,
   output logic             fault
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK, DONE} state_t;
   state_t           state, state_n;
   logic [15:0]      remain, remain_n, shortfall_n;
   logic [TW-1:0]    tmo, tmo_n;
   logic [INV_W-1:0] inv [6];
   logic [INV_W-1:0] inv_n [6];
   logic             coin_req_n, done_n, fault_n, found;
   logic [2:0]       coin_type_n, pick;
   function automatic logic [15:0] value(input logic [2:0] t);
      return t == 3'd0 ? 16'd500 : t == 3'd1 ? 16'd100 : t == 3'd2 ? 16'd25 :
             t == 3'd3 ? 16'd10 : t == 3'd4 ? 16'd5 : 16'd1;
   endfunction
   // Scan from the smallest coin upward so the largest eligible coin wins.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      for (int i = 5; i >= 0; i--)
         if (inv[i] != '0 && value(3'(i)) <= remain) begin
            found = 1'b1;
            pick  = 3'(i);
         end
   end
   always_comb begin
      state_n     = state;
      remain_n    = remain;
      tmo_n       = tmo;
      coin_req_n  = coin_req;
      coin_type_n = coin_type;
      shortfall_n = shortfall;
      fault_n     = fault;
      inv_n       = inv;
      case (state)
         IDLE: begin
            for (int i = 0; i < 6; i++)
               if (load && load_type == 3'(i)) inv_n[i] = load_count;
            if (start) begin
               remain_n = amount;
               state_n  = amount == 16'd0 ? DONE : SELECT;
               if (amount == 16'd0) shortfall_n = '0;
            end
         end
         SELECT: begin
            if (found) begin
               coin_type_n = pick;
               coin_req_n  = 1'b1;
               tmo_n       = '0;
               state_n     = WAIT_ACK;
            end else begin
               shortfall_n = remain;
               state_n     = DONE;
            end
         end
         WAIT_ACK: begin
            if (coin_ack) begin
               coin_req_n = 1'b0;
               remain_n   = remain - value(coin_type);
               for (int i = 0; i < 6; i++)
                  if (coin_type == 3'(i)) inv_n[i] = inv[i] - INV_W'(1);
               state_n = SELECT;
            end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
               coin_req_n  = 1'b0;
               fault_n     = 1'b1;
               shortfall_n = remain;
               state_n     = DONE;
            end else begin
               tmo_n = tmo + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      done_n = state_n == DONE;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         remain    <= '0;
         tmo       <= '0;
         coin_req  <= 1'b0;
         coin_type <= 3'd0;
         done      <= 1'b0;
         shortfall <= '0;
         fault     <= 1'b0;
         for (int i = 0; i < 6; i++) inv[i] <= INV_W'(INIT_COUNT);
      end else begin
         state     <= state_n;
         remain    <= remain_n;
         tmo       <= tmo_n;
         coin_req  <= coin_req_n;
         coin_type <= coin_type_n;
         done      <= done_n;
         shortfall <= shortfall_n;
         fault     <= fault_n;
         inv       <= inv_n;
      end
   end
   assign busy = state != IDLE;
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the physical coin hopper after a vending transaction completes.
- Takes the change amount from the vending FSM and breaks it into coins, largest-first.
- Issues one coin request at a time over a req/ack handshake and tracks per-denomination inventory.
- Reports any undispensable remainder and hopper faults.

Parameters:
INV_W, 8, width of each coin inventory counter
INIT_COUNT, 20, inventory value of every denomination after reset
ACK_TIMEOUT, 64, cycles allowed in WAIT_ACK before fault (minimum 1)

Ports:
CLK  input  1  clock, rising edge
I_RESET_N  input  1  synchronous active-low reset
I_START  input  1  one-cycle pulse: dispense I_AMOUNT (driven from vending O_SUCCESS/O_CHANGE path)
I_AMOUNT  input  16  change in cents, valid when I_START=1
I_LOAD  input  1  inventory write strobe
I_LOAD_TYPE  input  3  coin type to write (0..5)
I_LOAD_COUNT  input  INV_W  new inventory count
I_COIN_ACK  input  1  hopper has ejected the requested coin
O_COIN_REQ  output  1  request one coin of O_COIN_TYPE
O_COIN_TYPE  output  3  0=500, 1=100, 2=25, 3=10, 4=5, 5=1 cents
O_BUSY  output  1  high in any state other than IDLE
O_DONE  output  1  one-cycle completion pulse
O_SHORT  output  16  remainder not dispensed, valid from O_DONE until next I_START
O_FAULT  output  1  sticky hopper timeout flag

Behaviour:
Reset and registers
- Reset (I_RESET_N=0 at a rising edge) forces state IDLE.
- Reset values: O_COIN_REQ=0, O_COIN_TYPE=0, O_DONE=0, O_SHORT=0, O_FAULT=0, REMAIN=0, timeout counter=0, all six inventories=INIT_COUNT.
- Reset applies from any state, including mid-WAIT_ACK: REQ is low after that edge and no inventory decrement occurs.
- All outputs are registered; O_BUSY is decoded from the state register.

States
- IDLE:
  - I_START with I_AMOUNT=0: go DONE with O_SHORT=0.
  - I_START with I_AMOUNT>0: REMAIN<=I_AMOUNT, go SELECT.
- SELECT (one cycle):
  - Pick the lowest type index t with value(t)<=REMAIN and inv[t]>0.
  - If found: O_COIN_TYPE<=t, O_COIN_REQ<=1, clear timeout counter, go WAIT_ACK.
  - If REMAIN=0 or no eligible coin: O_SHORT<=REMAIN, go DONE.
- WAIT_ACK:
  - O_COIN_REQ and O_COIN_TYPE are held stable.
  - On I_COIN_ACK=1: O_COIN_REQ<=0, REMAIN<=REMAIN-value(t), inv[t]<=inv[t]-1, go SELECT.
  - Each cycle without ack increments the counter. When it reaches ACK_TIMEOUT: O_COIN_REQ<=0, O_FAULT<=1, O_SHORT<=REMAIN, no decrement, go DONE.
- DONE: O_DONE=1 for exactly this cycle, then IDLE.

Handshake
- Ack sampled in the same cycle REQ first rises counts.
- I_COIN_ACK while REQ=0 is ignored.
- REQ deasserts for at least one cycle (SELECT) between consecutive coins.

Arithmetic
- REMAIN is 16-bit unsigned and never underflows (the selection rule guarantees value<=REMAIN).
- Inventory never decrements below 0 (count-0 types are ineligible).

Latency
- With zero-wait ack, the first REQ is high 2 cycles after I_START.
- Each coin costs 2 cycles.
- O_DONE follows 1 cycle after the final SELECT.

Simultaneous and boundary events
- I_START while O_BUSY=1 is ignored.
- I_LOAD is accepted only in IDLE and replaces the count; it is ignored otherwise.
- I_LOAD_TYPE>5 is ignored.
- I_LOAD and I_START in the same IDLE cycle: both take effect; the load is visible to the first SELECT.
- O_FAULT is cleared only by reset. Later transactions still run while it is set.

Test Plan:
1. Reset, I_AMOUNT=165, ack 1 cycle after each REQ -> types 1,2,2,3,4 in order; O_SHORT=0; single O_DONE; inv[1]=19, inv[2]=18, inv[3]=19, inv[4]=19.
2. Load type 2 count 0, I_AMOUNT=30 -> types 3,3,3; O_SHORT=0; inv[3]=17.
3. Load type 4=0 and type 5=2, I_AMOUNT=7 -> types 5,5 then O_DONE with O_SHORT=5.
4. ACK_TIMEOUT=4, I_AMOUNT=100, never ack -> REQ high 4 cycles then low; O_FAULT=1; O_SHORT=100; inv[1] unchanged at 20.
5. I_START(50) mid-transaction, plus I_LOAD while busy -> both ignored, and first transaction coins/inventory unchanged. Separately, I_AMOUNT=0 -> O_DONE the cycle after I_START, no REQ.
6. I_RESET_N=0 during WAIT_ACK -> REQ=0 next edge; all inventories back to 20; state IDLE; O_FAULT=0.
